// File: rtl/serial_add_controller.sv
// Bit-serial WIDTH-bit adder: one 1-bit add cell plus carry flop, LSB first, WIDTH cycles per operation.
// Optional subtract mode via macro SERIAL_ADD_SUB_EN (adds sub_in port, computes A + ~B + 1).
module serial_add_controller #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_in,
`endif
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             hs1_sum, hs1_carry;
    logic             s_bit, c_next;
    logic [WIDTH-1:0] a_shift;
    logic             load_sub;

`ifdef SERIAL_ADD_SUB_EN
    assign load_sub = sub_in;
`else
    assign load_sub = 1'b0;
`endif

    // The A register doubles as the result register: each sum bit enters
    // at the MSB end as the consumed operand bit leaves the LSB end, so after
    // WIDTH shifts it holds the complete sum.
    generate
        if (WIDTH > 1) begin : g_shift_wide
            assign a_shift = {s_bit, a_q[WIDTH-1:1]};
        end else begin : g_shift_one
            assign a_shift = s_bit;
        end
    endgenerate

    always_comb begin
        hs1_sum   = a_q[0] ^ b_q[0];
        hs1_carry = a_q[0] & b_q[0];
        s_bit     = hs1_sum ^ c_q;
        c_next    = hs1_carry | (hs1_sum & c_q);

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = load_sub ? ~b_in : b_in;
                    c_d     = load_sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_shift;
                b_d   = b_q >> 1;
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                // Outputs load on the final bit so they are valid throughout DONE.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = a_shift;
                    carry_d = c_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_out  = busy_q;
    assign done_out  = done_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;

endmodule
